key_debounce_bank: RTL and testbench

KEY_DEBOUNCE_BANK -- requirements
Module: key_debounce_bank

---
 rtl/bk_input_pkg.sv | 22 ++
 rtl/key_debounce_chan.sv | 124 ++++++++++++
 rtl/key_debounce_bank.sv | 45 ++++
 tb/tb_key_debounce_bank.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/bk_input_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | bk_input_pkg : key-debounce state encoding and parameter limits        |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
package bk_input_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } key_state_e;

  localparam int c_nchan_min      = 1;
  localparam int c_nchan_max      = 16;
  localparam int c_deb_cycles_min = 2;
  localparam int c_deb_cycles_max = (1 << 20) - 1;

endpackage : bk_input_pkg
`default_nettype wire

// File: rtl/key_debounce_chan.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | key_debounce_chan : one key channel - synchronizer, debounce FSM,      |
// | press/release pulses, toggle and long-press detection. Rev 1.0         |
// +----------------------------------------------------------------------+
module key_debounce_chan
  import bk_input_pkg::*;
#(
  parameter int   DEB_CYCLES  = 65535,
  parameter int   HOLD_CYCLES = 12500000,
  parameter logic TOGGLE_INIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_n,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_toggle,
  output logic o_hold,
  output logic o_held
);

  localparam int                c_deb_w    = $clog2(DEB_CYCLES);
  localparam int                c_hold_w   = $clog2(HOLD_CYCLES + 1);
  localparam logic [c_deb_w-1:0]  c_deb_one  = c_deb_w'(1);
  localparam logic [c_deb_w-1:0]  c_deb_last = c_deb_w'(DEB_CYCLES - 1);
  localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(HOLD_CYCLES);
  localparam logic [c_hold_w-1:0] c_hold_pre = c_hold_w'(HOLD_CYCLES - 1);

  // Synchronizer carries the pressed polarity so its reset value means "released".
  logic [1:0]          r_sync;
  key_state_e          r_state;
  key_state_e          w_state_nxt;
  logic [c_deb_w-1:0]  r_deb_cnt;
  logic [c_deb_w-1:0]  w_deb_cnt_nxt;
  logic [c_hold_w-1:0] r_hold_cnt;
  logic                r_press;
  logic                r_release;
  logic                r_toggle;
  logic                r_hold;
  logic                r_held;
  logic                w_s;
  logic                w_level;
  logic                w_enter_press;
  logic                w_enter_idle;
  logic                w_hold_hit;

  assign w_s     = r_sync[1];
  assign w_level = (r_state == ST_PRESSED) || (r_state == ST_RELEASE_WAIT);

  always_comb begin
    w_state_nxt   = r_state;
    w_deb_cnt_nxt = r_deb_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_s) begin
          w_state_nxt   = ST_PRESS_WAIT;
          w_deb_cnt_nxt = c_deb_one;
        end
      end
      ST_PRESS_WAIT: begin
        if (!w_s)                        w_state_nxt   = ST_IDLE;
        else if (r_deb_cnt == c_deb_last) w_state_nxt   = ST_PRESSED;
        else                             w_deb_cnt_nxt = r_deb_cnt + 1'b1;
      end
      ST_PRESSED: begin
        if (!w_s) begin
          w_state_nxt   = ST_RELEASE_WAIT;
          w_deb_cnt_nxt = c_deb_one;
        end
      end
      ST_RELEASE_WAIT: begin
        if (w_s)                         w_state_nxt   = ST_PRESSED;
        else if (r_deb_cnt == c_deb_last) w_state_nxt   = ST_IDLE;
        else                             w_deb_cnt_nxt = r_deb_cnt + 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_enter_press = (r_state == ST_PRESS_WAIT) && (w_state_nxt == ST_PRESSED);
  assign w_enter_idle  = (r_state == ST_RELEASE_WAIT) && (w_state_nxt == ST_IDLE);
  // Release wins over a hold landing on the same edge, so held never outlives level.
  assign w_hold_hit    = w_level && !w_enter_idle && (r_hold_cnt == c_hold_pre);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync     <= 2'b00;
      r_state    <= ST_IDLE;
      r_deb_cnt  <= '0;
      r_hold_cnt <= '0;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
      r_toggle   <= TOGGLE_INIT;
      r_hold     <= 1'b0;
      r_held     <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], ~i_key_n};
      r_state   <= w_state_nxt;
      r_deb_cnt <= w_deb_cnt_nxt;
      r_press   <= w_enter_press;
      r_release <= w_enter_idle;
      r_hold    <= w_hold_hit;
      if (w_enter_press) r_toggle <= ~r_toggle;
      if (w_enter_press)
        r_hold_cnt <= '0;
      else if (w_level && !w_enter_idle && (r_hold_cnt != c_hold_max))
        r_hold_cnt <= r_hold_cnt + 1'b1;
      if (w_enter_idle)    r_held <= 1'b0;
      else if (w_hold_hit) r_held <= 1'b1;
    end
  end

  assign o_level   = w_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_toggle  = r_toggle;
  assign o_hold    = r_hold;
  assign o_held    = r_held;

endmodule : key_debounce_chan
`default_nettype wire

// File: rtl/key_debounce_bank.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | key_debounce_bank : NCHAN independent debounced key channels           |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module key_debounce_bank
  import bk_input_pkg::*;
#(
  parameter int               NCHAN       = 4,
  parameter int               DEB_CYCLES  = 65535,
  parameter int               HOLD_CYCLES = 12500000,
  parameter logic [NCHAN-1:0] TOGGLE_INIT = '0
) (
  input  logic             clk25,
  input  logic             reset_n,
  input  logic [NCHAN-1:0] keys_n,
  output logic [NCHAN-1:0] level_o,
  output logic [NCHAN-1:0] press_o,
  output logic [NCHAN-1:0] release_o,
  output logic [NCHAN-1:0] toggle_o,
  output logic [NCHAN-1:0] hold_o,
  output logic [NCHAN-1:0] held_o
);

  for (genvar gi = 0; gi < NCHAN; gi++) begin : g_chan
    key_debounce_chan #(
      .DEB_CYCLES  (DEB_CYCLES),
      .HOLD_CYCLES (HOLD_CYCLES),
      .TOGGLE_INIT (TOGGLE_INIT[gi])
    ) u_chan (
      .clk       (clk25),
      .rst_n     (reset_n),
      .i_key_n   (keys_n[gi]),
      .o_level   (level_o[gi]),
      .o_press   (press_o[gi]),
      .o_release (release_o[gi]),
      .o_toggle  (toggle_o[gi]),
      .o_hold    (hold_o[gi]),
      .o_held    (held_o[gi])
    );
  end : g_chan

endmodule : key_debounce_bank
`default_nettype wire

// File: tb/tb_key_debounce_bank.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_key_debounce_bank : directed self-checking bench, NCHAN=4,          |
// | DEB_CYCLES=4, HOLD_CYCLES=20, TOGGLE_INIT=4'b0010. Rev 1.0             |
// +----------------------------------------------------------------------+
module tb_key_debounce_bank;

  logic       clk25 = 1'b0;
  logic       reset_n;
  logic [3:0] keys_n;
  logic [3:0] level_o, press_o, release_o, toggle_o, hold_o, held_o;

  int n_checks = 0;
  int n_fail   = 0;

  key_debounce_bank #(
    .NCHAN       (4),
    .DEB_CYCLES  (4),
    .HOLD_CYCLES (20),
    .TOGGLE_INIT (4'b0010)
  ) dut (
    .clk25     (clk25),
    .reset_n   (reset_n),
    .keys_n    (keys_n),
    .level_o   (level_o),
    .press_o   (press_o),
    .release_o (release_o),
    .toggle_o  (toggle_o),
    .hold_o    (hold_o),
    .held_o    (held_o)
  );

  always #5 clk25 = ~clk25;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk25);
    #1;
  endtask

  initial begin
    logic [3:0] acc_press, acc_rel, acc_lvl, acc_hold, seen_press;
    int         rel_cnt, edge_at, hold_cnt;
    logic       held_at_rel;

    reset_n = 1'b0;
    keys_n  = 4'hF;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    chk("rst_toggle",  toggle_o,  4'b0010);
    chk("rst_level",   level_o,   4'b0000);
    chk("rst_press",   press_o,   4'b0000);
    chk("rst_release", release_o, 4'b0000);
    chk("rst_hold",    hold_o,    4'b0000);
    chk("rst_held",    held_o,    4'b0000);

    // Channel 0 press: level rises on the 6th edge after the fall.
    keys_n[0] = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("ch0_level_early", level_o, 4'b0000);
    tick();
    chk("ch0_level_rise", level_o,  4'b0001);
    chk("ch0_press",      press_o,  4'b0001);
    chk("ch0_toggle",     toggle_o, 4'b0011);
    tick();
    chk("ch0_press_1cyc", press_o, 4'b0000);
    for (int i = 0; i < 18; i++) tick();
    chk("ch0_hold_early", hold_o, 4'b0000);
    tick();
    chk("ch0_hold_pulse", hold_o, 4'b0001);
    chk("ch0_held_set",   held_o, 4'b0001);
    tick();
    chk("ch0_hold_1cyc", hold_o, 4'b0000);
    chk("ch0_held_stay", held_o, 4'b0001);

    // Channel 1 bounce: five 3-cycle lows with 1-cycle gaps.
    acc_press = '0; acc_rel = '0; acc_lvl = '0; acc_hold = '0;
    for (int p = 0; p < 5; p++) begin
      keys_n[1] = 1'b0;
      for (int i = 0; i < 3; i++) begin
        tick();
        acc_press |= press_o; acc_rel |= release_o; acc_lvl |= level_o; acc_hold |= hold_o;
      end
      keys_n[1] = 1'b1;
      tick();
      acc_press |= press_o; acc_rel |= release_o; acc_lvl |= level_o; acc_hold |= hold_o;
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      acc_press |= press_o; acc_rel |= release_o; acc_lvl |= level_o; acc_hold |= hold_o;
    end
    chk("ch1_bounce_press", acc_press, 4'b0000);
    chk("ch1_bounce_rel",   acc_rel,   4'b0000);
    chk("ch1_bounce_level", acc_lvl,   4'b0001);
    chk("ch1_bounce_hold",  acc_hold,  4'b0000);
    chk("ch1_bounce_tog",   toggle_o,  4'b0011);

    // Channel 0 release with a 2-cycle bounce before settling high.
    acc_press = '0; acc_hold = '0; rel_cnt = 0; held_at_rel = 1'b1;
    keys_n[0] = 1'b1;
    tick(); acc_press |= press_o; acc_hold |= hold_o;
    tick(); acc_press |= press_o; acc_hold |= hold_o;
    keys_n[0] = 1'b0;
    tick(); acc_press |= press_o; acc_hold |= hold_o;
    keys_n[0] = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      acc_press |= press_o; acc_hold |= hold_o;
      if (release_o[0]) begin
        rel_cnt++;
        held_at_rel = held_o[0];
      end
    end
    chk("ch0_rel_count",    rel_cnt,     1);
    chk("ch0_held_cleared", held_at_rel, 1'b0);
    chk("ch0_rel_nopress",  acc_press,   4'b0000);
    chk("ch0_rel_nohold",   acc_hold,    4'b0000);
    chk("ch0_rel_level",    level_o,     4'b0000);

    // Channels 2 and 3 pressed together.
    seen_press = '0; edge_at = -1;
    keys_n[3:2] = 2'b00;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (press_o != 4'b0000 && edge_at < 0) begin
        seen_press = press_o;
        edge_at    = i;
      end
    end
    chk("ch23_press",   seen_press, 4'b1100);
    chk("ch23_latency", edge_at,    6);
    chk("ch23_toggle",  toggle_o,   4'b1111);
    keys_n[3:2] = 2'b11;
    for (int i = 0; i < 10; i++) tick();
    chk("ch23_released", level_o, 4'b0000);

    // Reset in the middle of a hold on channel 0.
    keys_n[0] = 1'b0;
    edge_at = -1;
    for (int i = 1; i <= 12 && edge_at < 0; i++) begin
      tick();
      if (level_o[0]) edge_at = i;
    end
    chk("ch0_repress_lat", edge_at, 6);
    for (int i = 0; i < 10; i++) tick();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_level",  level_o,  4'b0000);
    chk("mid_rst_toggle", toggle_o, 4'b0010);
    chk("mid_rst_held",   held_o,   4'b0000);
    tick(); tick();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("post_rst_early", level_o, 4'b0000);
    tick();
    chk("post_rst_level",  level_o,  4'b0001);
    chk("post_rst_press",  press_o,  4'b0001);
    chk("post_rst_toggle", toggle_o, 4'b0011);
    hold_cnt = 0; edge_at = -1;
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (hold_o[0]) begin
        hold_cnt++;
        if (edge_at < 0) edge_at = i;
      end
    end
    chk("post_rst_hold_at",  edge_at,  20);
    chk("post_rst_hold_cnt", hold_cnt, 1);
    chk("post_rst_held",     held_o,   4'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule : tb_key_debounce_bank
`default_nettype wire
